// File: rtl/mult_unit.sv
// Iterative 32x32 shift-add multiplier that owns HI/LO and raises the
// pipeline stall request while a product is still pending.
module mult_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sgn,
    input  logic [31:0] srca,
    input  logic [31:0] srcb,
    input  logic        hilo_rd,
    input  logic        mult_d,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        stall
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [63:0] acc_q, acc_d;
    logic [31:0] mcand_q, mcand_d;
    logic [31:0] mplier_q, mplier_d;
    logic        neg_q, neg_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [32:0] sum;

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        neg_d    = neg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        sum      = 33'd0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Negating 0x80000000 yields 0x80000000, which is the
                    // correct magnitude when read as unsigned.
                    mcand_d  = (sgn && srca[31]) ? (32'd0 - srca) : srca;
                    mplier_d = (sgn && srcb[31]) ? (32'd0 - srcb) : srcb;
                    neg_d    = sgn & (srca[31] ^ srcb[31]);
                    acc_d    = 64'd0;
                    count_d  = 5'd0;
                    busy_d   = 1'b1;
                    state_d  = S_RUN;
                end
            end
            S_RUN: begin
                sum      = {1'b0, acc_q[63:32]} + (mplier_q[0] ? {1'b0, mcand_q} : 33'd0);
                acc_d    = {sum, acc_q[31:1]};
                mplier_d = mplier_q >> 1;
                count_d  = count_q + 5'd1;
                if (count_q == 5'd31) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                {hi_d, lo_d} = neg_q ? (64'd0 - acc_q) : acc_q;
                done_d       = 1'b1;
                busy_d       = 1'b0;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            count_q  <= 5'd0;
            acc_q    <= 64'd0;
            mcand_q  <= 32'd0;
            mplier_q <= 32'd0;
            neg_q    <= 1'b0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            neg_q    <= neg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign hi    = hi_q;
    assign lo    = lo_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign stall = busy_q & (hilo_rd | mult_d);

endmodule

// File: tb/tb_mult_unit.sv
// Directed self-checking bench for mult_unit: products, latency, done
// pulse, stall window, ignored restart and mid-operation reset.
module tb_mult_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        sgn;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        hilo_rd;
    logic        mult_d;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        stall;

    int n_checks = 0;
    int n_errors = 0;

    mult_unit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .sgn     (sgn),
        .srca    (srca),
        .srcb    (srcb),
        .hilo_rd (hilo_rd),
        .mult_d  (mult_d),
        .hi      (hi),
        .lo      (lo),
        .busy    (busy),
        .done    (done),
        .stall   (stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issues one operation and watches 40 cycles after the start edge E0.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic use_rd, input logic restart);
        logic [31:0] prev_hi;
        logic [31:0] prev_lo;
        int done_n;
        int done_at;
        int stall_n;
        prev_hi = hi;
        prev_lo = lo;
        done_n  = 0;
        done_at = -1;
        stall_n = 0;
        @(negedge clk);
        start = 1'b1;
        sgn   = s;
        srca  = a;
        srcb  = b;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        srca    = 'x;
        srcb    = 'x;
        hilo_rd = use_rd;
        #1;
        if (stall) stall_n++;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (restart && i == 4) begin
                start = 1'b1;
                sgn   = 1'b0;
                srca  = 32'd2;
                srcb  = 32'd3;
            end else if (restart && i == 5) begin
                start = 1'b0;
                srca  = 'x;
                srcb  = 'x;
            end
            #1;
            if (stall) stall_n++;
            if (done) begin
                done_n++;
                if (done_at < 0) done_at = i;
            end
            if (i == 32) begin
                check({tag, "_busy_e32"}, {63'd0, busy}, 64'd1);
                check({tag, "_old_hilo"}, {hi, lo}, {prev_hi, prev_lo});
            end
            if (i == 33) check({tag, "_busy_e33"}, {63'd0, busy}, 64'd0);
        end
        hilo_rd = 1'b0;
        check({tag, "_hilo"}, {hi, lo}, {exp_hi, exp_lo});
        check({tag, "_done_n"}, 64'(done_n), 64'd1);
        check({tag, "_done_at"}, 64'(done_at), 64'd33);
        if (use_rd) check({tag, "_stall_n"}, 64'(stall_n), 64'd33);
    endtask

    initial begin
        int done_n;
        rst     = 1'b1;
        start   = 1'b0;
        sgn     = 1'b0;
        srca    = 32'd0;
        srcb    = 32'd0;
        hilo_rd = 1'b0;
        mult_d  = 1'b0;
        #12;
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_flags", {61'd0, busy, done, stall}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        hilo_rd = 1'b1;
        mult_d  = 1'b1;
        #1;
        check("idle_stall", {63'd0, stall}, 64'd0);
        hilo_rd = 1'b0;
        mult_d  = 1'b0;

        run_op("umax", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001, 1'b1, 1'b0);
        run_op("sneg", 32'hFFFFFFFD, 32'd5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 1'b0);
        run_op("uneg", 32'hFFFFFFFD, 32'd5, 1'b0, 32'h00000004, 32'hFFFFFFF1, 1'b0, 1'b0);
        run_op("smin", 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000, 1'b0, 1'b0);
        run_op("sm1", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h00000000, 32'h00000001, 1'b1, 1'b0);
        run_op("busy_start", 32'h12345678, 32'h00000010, 1'b0, 32'h00000001, 32'h23456780, 1'b0, 1'b1);

        // Mid-operation reset: start at E0, rst pulsed around E10.
        done_n = 0;
        @(negedge clk);
        start = 1'b1;
        sgn   = 1'b0;
        srca  = 32'hFFFFFFFF;
        srcb  = 32'hFFFFFFFF;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 9) rst = 1'b1;
            if (i == 10) rst = 1'b0;
            #1;
            if (done) done_n++;
        end
        check("rst_mid_hilo", {hi, lo}, 64'd0);
        check("rst_mid_busy", {63'd0, busy}, 64'd0);
        check("rst_mid_done", 64'(done_n), 64'd0);

        run_op("post_rst", 32'd7, 32'd6, 1'b0, 32'd0, 32'd42, 1'b0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mult_unit.md
# mult_unit

Iterative 32x32 multiplier owning the HI/LO registers. It executes the mult and multu operations flagged by the decode controller (multstart, multsgn) and supplies HI/LO to mfhi/mflo writeback. It also produces the stall request that holds the front of the pipeline while a product is pending. It sits beside the ALU in the execute stage.

## Interface
- No parameters; data width fixed at 32, product width at 64.
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  multstart of the instruction in execute; single-cycle qualifier.
- sgn  in  1  1 = signed (mult), 0 = unsigned (multu); sampled with start.
- srca  in  32  multiplicand (rs value after forwarding); sampled with start.
- srcb  in  32  multiplier (rt value after forwarding); sampled with start.
- hilo_rd  in  1  instruction in decode is mfhi or mflo (wbsrc selects HI/LO).
- mult_d  in  1  instruction in decode is mult or multu.
- hi  out  32  HI register (upper product word).
- lo  out  32  LO register (lower product word).
- busy  out  1  multiplication in progress.
- done  out  1  one-cycle pulse; HI/LO just updated.
- stall  out  1  pipeline stall request = busy & (hilo_rd | mult_d).

## Operation
- States: IDLE, RUN, FIX.
- IDLE with start=1:
  - Latch |srca| and |srcb|. Absolute value applies only when sgn=1 and bit 31=1; otherwise latch the raw operand. 0x80000000 is held as an unsigned magnitude.
  - Latch neg = sgn & (srca[31] ^ srcb[31]).
  - Clear the 64-bit accumulator and the 5-bit count; go to RUN.
- RUN, one multiplier bit per cycle, LSB first:
  - If the multiplier LSB is 1, add the multiplicand to the upper half of the accumulator. Keep the carry-out in a 33-bit sum.
  - Shift {carry, accumulator} right by one. Shift the multiplier right by one.
  - count increments. The cycle with count==31 goes to FIX.
- FIX:
  - hi:lo <= neg ? (two's complement of the 64-bit accumulator) : accumulator.
  - done=1; go to IDLE.
- start in RUN or FIX is ignored. No queueing occurs; the stall output keeps a correct pipeline from issuing one.
- hi/lo hold their previous values throughout RUN. They change only on the FIX edge.
- stall is combinational from registered busy and the decode-stage inputs.
- hilo_rd or mult_d while idle gives stall=0.
- Unknown/X on srca/srcb when start=0 has no effect.

## Timing
- Reset values (async assert):
  - state=IDLE, count=0, accumulator=0, neg=0.
  - hi=0, lo=0, busy=0, done=0, stall=0.
- Mid-operation reset aborts the computation and zeroes hi/lo.
- Edge E0 samples start in IDLE. busy=1 from after E0 until after E33.
- RUN occupies edges E1..E32. E33 is the FIX edge: hi/lo updated, done=1 for the cycle after E33, busy=0.
- Latency is 33 cycles from the start edge to HI/LO valid. mfhi/mflo in decode during busy stalls 33 cycles at most.
- start and IDLE on the same edge as FIX completion cannot coincide, because FIX returns to IDLE. A start on the edge immediately after E33 is accepted. Back-to-back throughput is one product per 34 cycles.
- Release of rst is synchronous to clk.

## Test plan
- Unsigned: srca=0xFFFFFFFF, srcb=0xFFFFFFFF, sgn=0 -> after 33 cycles hi=0xFFFFFFFE, lo=0x00000001, done pulses once.
- Signed negative result: srca=0xFFFFFFFD (-3), srcb=5, sgn=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Same operands with sgn=0 -> hi=0x00000004, lo=0xFFFFFFF1.
- Signed extremes: 0x80000000 x 0x80000000, sgn=1 -> hi=0x40000000, lo=0x00000000. -1 x -1 -> hi=0, lo=1.
- Stall:
  - hilo_rd=1 held from E1 -> stall=1 every cycle through E33, 0 after.
  - hilo_rd=1 while idle -> stall=0.
  - Old hi/lo values are visible until E33.
- Start while busy: second start at E5 with srca=2, srcb=3 -> ignored; result is the first operation's product, with a single done pulse.
- Reset mid-op: rst pulsed at E10 -> hi=lo=0, busy=0, done never pulses. A new start 7 x 6 afterwards yields lo=42, hi=0.
